fetch_sequencer: RTL and testbench

//  Sequences instruction fetch between the PC register, instruction memory and decode.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_target_calc.sv | 23 ++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t    : sequencer state encoding
//   INSTR_BYTES      : PC increment per fetched instruction
//   XLEN_DEFAULT     : default address/data width
//   RESET_PC_DEFAULT : default PC loaded on reset
//   IMM_W_DEFAULT    : default width of the signed redirect offset
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam int unsigned IMM_W_DEFAULT    = 12;

endpackage

// File: rtl/fetch_target_calc.sv
// Redirect target calculation (purely combinational).
//   base   in  XLEN   PC of the redirecting instruction
//   offset in  IMM_W  signed byte offset
//   target out XLEN   base + sext(offset), word aligned, wraps at 2^XLEN
module fetch_target_calc #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IMM_W = 12
) (
  input  logic [XLEN-1:0]  base,
  input  logic [IMM_W-1:0] offset,
  output logic [XLEN-1:0]  target
);

  logic [XLEN-1:0] offset_sext;
  logic [XLEN-1:0] sum;

  always_comb begin
    offset_sext = {{(XLEN-IMM_W){offset[IMM_W-1]}}, offset};
    sum         = base + offset_sext;
    target      = {sum[XLEN-1:2], 2'b00};
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one imem request at a time, hands each
// response to decode as an instruction/PC pair, applies branch/jump redirects
// and discards responses that belong to pre-redirect requests.
//   clk, reset (async, active-high)
//   imem_req_valid/ready/addr  : request channel to instruction memory
//   imem_rsp_valid/data        : response channel (one per accepted request)
//   inst_valid/ready/data/pc   : instruction channel to decode
//   redirect_valid/base/off    : taken branch or jump resolved this cycle
//   perf_fetches/perf_stalls   : event counters
// Optional feature macro: FETCH_PERF_EN enables the performance counters;
// without it both counters read as constant zero.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     IMM_W    = IMM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  inst_data,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_base,
  input  logic [IMM_W-1:0] redirect_off,
  output logic [31:0]      perf_fetches,
  output logic [31:0]      perf_stalls
);

  fetch_state_t    state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] fetch_pc, fetch_pc_d;
  logic [XLEN-1:0] inst_data_q, inst_pc_q;
  logic [XLEN-1:0] target;
  logic            capture;

  fetch_target_calc #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W)
  ) u_target (
    .base   (redirect_base),
    .offset (redirect_off),
    .target (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      fetch_pc <= fetch_pc_d;
      if (capture) begin
        inst_data_q <= imem_rsp_data;
        inst_pc_q   <= fetch_pc;
      end
    end
  end

  // Redirect takes priority over every handshake and always reloads the PC.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    fetch_pc_d = fetch_pc;
    capture    = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = target;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = target;
          // An accepted request on the redirect cycle is already stale.
          state_d = imem_req_ready ? S_DROP : S_REQ;
        end else if (imem_req_ready) begin
          state_d    = S_WAIT;
          fetch_pc_d = pc;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          capture = 1'b1;
          pc_d    = pc + XLEN'(INSTR_BYTES);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (inst_ready) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = target;
        // A stale response arriving alongside a further redirect is still
        // the one outstanding response, so it retires the drop either way.
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_req_addr  = pc;
    inst_valid     = (state == S_HOLD);
    inst_data      = inst_data_q;
    inst_pc        = inst_pc_q;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (inst_valid) begin
      if (inst_ready) fetch_cnt <= fetch_cnt + 32'd1;
      else            stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetches = fetch_cnt;
  assign perf_stalls  = stall_cnt;
`else
  assign perf_fetches = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model of the
// fetch rules and a single-outstanding memory responder.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_base;
  logic [11:0] redirect_off;
  logic [31:0] perf_fetches;
  logic [31:0] perf_stalls;

  fetch_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .IMM_W    (12)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_base  (redirect_base),
    .redirect_off   (redirect_off),
    .perf_fetches   (perf_fetches),
    .perf_stalls    (perf_stalls)
  );

  always #5 clk = ~clk;

  int tests;
  int fails;

  // Model: what the sequencer should be doing, in transaction terms.
  bit          m_boot;   // the single idle cycle after reset
  logic [31:0] m_pc;
  bit          m_busy;   // a request is outstanding
  bit          m_stale;  // outstanding request predates a redirect
  logic [31:0] m_fpc;
  bit          m_hold;   // an instruction is being offered to decode
  logic [31:0] m_hdata;
  logic [31:0] m_hpc;
  logic [31:0] m_fetches;
  logic [31:0] m_stalls;

  // Memory responder state.
  bit          mem_pending;
  int unsigned mem_wait;
  logic [31:0] mem_addr;
  int unsigned lat_lo, lat_hi;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] b, input logic [11:0] o);
    logic [31:0] so;
    so = 32'($signed(o));
    return (b + so) & 32'hFFFF_FFFC;
  endfunction

  function automatic bit m_req();
    return !m_boot && !m_busy && !m_hold;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pc = 32'h0; m_busy = 0; m_stale = 0; m_fpc = '0;
    m_hold = 0; m_hdata = '0; m_hpc = '0; m_fetches = '0; m_stalls = '0;
  endtask

  // Advance model and responder across one rising edge using the inputs
  // that were presented during the cycle.
  task automatic model_update();
    logic [31:0] tgt;
    bit req;
    if (reset) begin
      model_reset();
      return;
    end
    tgt = tgt_of(redirect_base, redirect_off);
    req = m_req();
    if (m_hold) begin
      if (inst_ready) m_fetches = m_fetches + 1;
      else            m_stalls  = m_stalls + 1;
    end
    if (imem_rsp_valid) mem_pending = 0;
    if (req && imem_req_ready) begin
      mem_pending = 1;
      mem_addr    = m_pc;
      mem_wait    = $urandom_range(lat_hi, lat_lo);
    end
    if (redirect_valid) begin
      if (m_boot) m_boot = 0;
      else if (req) begin
        if (imem_req_ready) begin m_busy = 1; m_stale = 1; end
      end else if (m_busy) begin
        if (imem_rsp_valid) m_busy = 0;
        else m_stale = 1;
      end else if (m_hold) m_hold = 0;
      m_pc = tgt;
    end else begin
      if (m_boot) m_boot = 0;
      else if (req) begin
        if (imem_req_ready) begin m_busy = 1; m_stale = 0; m_fpc = m_pc; end
      end else if (m_busy) begin
        if (imem_rsp_valid) begin
          m_busy = 0;
          if (!m_stale) begin
            m_hold  = 1;
            m_hdata = imem_rsp_data;
            m_hpc   = m_fpc;
            m_pc    = m_pc + 32'd4;
          end
        end
      end else if (m_hold && inst_ready) m_hold = 0;
    end
  endtask

  task automatic compare_all();
    chk("req_valid", 32'(imem_req_valid), 32'(m_req()));
    if (m_req()) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_hold));
    chk("inst_data", inst_data, m_hdata);
    chk("inst_pc", inst_pc, m_hpc);
`ifdef FETCH_PERF_EN
    chk("perf_fetches", perf_fetches, m_fetches);
    chk("perf_stalls", perf_stalls, m_stalls);
`else
    chk("perf_fetches", perf_fetches, 32'h0);
    chk("perf_stalls", perf_stalls, 32'h0);
`endif
  endtask

  // One clock cycle: drive inputs (just after a falling edge), take the
  // rising edge into the model, then check outputs at the next falling edge.
  task automatic tick(input bit rdy, input bit irdy, input bit redir,
                      input logic [31:0] base, input logic [11:0] off);
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_base  = base;
    redirect_off   = off;
    if (mem_pending && mem_wait == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_pending) mem_wait--;
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    tests = 0; fails = 0;
    clk = 0; reset = 1;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    inst_ready = 0; redirect_valid = 0; redirect_base = '0; redirect_off = '0;
    lat_lo = 0; lat_hi = 0; mem_pending = 0; mem_wait = 0; mem_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    compare_all();
    chk("reset req_valid", 32'(imem_req_valid), 32'h0);
    chk("reset inst_valid", 32'(inst_valid), 32'h0);
    chk("reset inst_data", inst_data, 32'h0);
    chk("reset inst_pc", inst_pc, 32'h0);

    // Sequential fetch with immediate accept and one-cycle responses.
    tick(1, 1, 0, '0, '0);
    chk("first req_valid", 32'(imem_req_valid), 32'h1);
    chk("first addr", imem_req_addr, 32'h0);
    tick(1, 1, 0, '0, '0);
    chk("inst_valid one cycle after accept", 32'(inst_valid), 32'h0);
    tick(1, 1, 0, '0, '0);
    chk("inst_valid two cycles after accept", 32'(inst_valid), 32'h1);
    chk("first inst_pc", inst_pc, 32'h0);
    chk("first inst_data", inst_data, mem_word(32'h0));
    tick(1, 1, 0, '0, '0);
    chk("second addr", imem_req_addr, 32'h4);
    tick(1, 1, 0, '0, '0);
    tick(1, 1, 0, '0, '0);
    chk("second inst_pc", inst_pc, 32'h4);
    tick(1, 1, 0, '0, '0);
    chk("third addr", imem_req_addr, 32'h8);

    // Memory not ready: request held steady.
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, '0, '0);
      chk("stall req_valid", 32'(imem_req_valid), 32'h1);
      chk("stall addr", imem_req_addr, 32'h8);
    end

    // Decode not ready: instruction held.
    tick(1, 0, 0, '0, '0);
    tick(1, 0, 0, '0, '0);
    chk("hold inst_pc", inst_pc, 32'h8);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, '0, '0);
      chk("held inst_valid", 32'(inst_valid), 32'h1);
      chk("held inst_pc", inst_pc, 32'h8);
      chk("held inst_data", inst_data, mem_word(32'h8));
    end
`ifdef FETCH_PERF_EN
    chk("perf_stalls after hold", perf_stalls, 32'd4);
    chk("perf_fetches before release", perf_fetches, 32'd2);
`endif
    tick(1, 1, 0, '0, '0);
    chk("addr after hold", imem_req_addr, 32'hC);

    // Redirect while waiting: the in-flight response is stale.
    lat_lo = 1; lat_hi = 1;
    tick(1, 1, 0, '0, '0);
    lat_lo = 0; lat_hi = 0;
    tick(1, 1, 1, 32'h100, 12'hFF8);
    chk("drop inst_valid", 32'(inst_valid), 32'h0);
    tick(1, 1, 0, '0, '0);
    chk("stale rsp not presented", 32'(inst_valid), 32'h0);
    chk("redirect addr", imem_req_addr, 32'hF8);
    tick(1, 1, 0, '0, '0);
    tick(1, 1, 0, '0, '0);
    chk("redirected inst_pc", inst_pc, 32'hF8);

    // Redirect while holding: instruction squashed even with inst_ready.
    tick(1, 1, 1, 32'h0, 12'h7FE);
    chk("squash inst_valid", 32'(inst_valid), 32'h0);
    chk("squash addr", imem_req_addr, 32'h7FC);

    // PC wrap from the top of the address space.
    tick(0, 1, 1, 32'hFFFF_FFF0, 12'h00C);
    chk("top addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(1, 1, 0, '0, '0);
    tick(1, 1, 0, '0, '0);
    chk("top inst_pc", inst_pc, 32'hFFFF_FFFC);
    tick(1, 1, 0, '0, '0);
    chk("wrapped addr", imem_req_addr, 32'h0);

    // Reset during a wait; the response arrives after reset and is ignored.
    lat_lo = 2; lat_hi = 2;
    tick(1, 1, 0, '0, '0);
    lat_lo = 0; lat_hi = 0;
    @(posedge clk);
    model_update();
    #1 reset = 1;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("async reset req_valid", 32'(imem_req_valid), 32'h0);
    chk("async reset inst_valid", 32'(inst_valid), 32'h0);
    chk("async reset inst_data", inst_data, 32'h0);
    chk("async reset inst_pc", inst_pc, 32'h0);
    mem_wait = 1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset = 0;
    compare_all();
    for (int i = 0; i < 8 && mem_pending; i++) tick(0, 1, 0, '0, '0);
    chk("late rsp delivered", 32'(mem_pending), 32'h0);
    chk("post-reset req_valid", 32'(imem_req_valid), 32'h1);
    chk("post-reset addr", imem_req_addr, 32'h0);
    chk("post-reset inst_valid", 32'(inst_valid), 32'h0);

    // Randomized traffic.
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(99) < 70, $urandom_range(99) < 70,
           $urandom_range(99) < 8, $urandom, 12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
